input_skewer: RTL

INPUT_SKEWER -- requirements
Module: input_skewer

---
 rtl/npu_pkg.sv | 23 ++
 rtl/skew_delay_line.sv | 39 +++
 rtl/input_skewer.sv | 107 ++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// Shared NPU types: precision modes and the input skewer state encoding.
// Also supplies the shared DATA_WIDTH default when no build define overrides it.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package npu_pkg;

  localparam int unsigned BUBBLE_CNT_W = 16;

  typedef enum logic [1:0] {
    PREC_INT8  = 2'd0,
    PREC_INT16 = 2'd1,
    PREC_FP16  = 2'd2
  } precision_mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } skewer_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register carrying one row's data word plus its last marker.
// o_last_nxt_c is the last marker the output stage will hold after the next edge.
module skew_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_last,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last,
  output logic             o_last_nxt_c
);

  localparam int unsigned STAGE_W = WIDTH + 1;

  logic [STAGE_W-1:0] r_stage [DEPTH];

  // Stage word is {last, data}; shifts every cycle, synchronous clear wins.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int i = 0; i < int'(DEPTH); i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= {i_last, i_data};
      for (int i = 1; i < int'(DEPTH); i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_data = r_stage[DEPTH-1][WIDTH-1:0];
  assign o_last = r_stage[DEPTH-1][WIDTH];

  if (DEPTH > 1) begin : g_deep
    assign o_last_nxt_c = !i_clr && r_stage[DEPTH-2][WIDTH];
  end else begin : g_shallow
    assign o_last_nxt_c = !i_clr && i_last;
  end

endmodule

// File: rtl/input_skewer.sv
// Diagonal input skewer for a systolic array: row r lags acceptance by r+1 cycles.
// Optional bubble counter enabled by defining SKEWER_BUBBLE_CNT_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module input_skewer
  import npu_pkg::*;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] in_data,
  input  logic                     in_last,
  input  logic                     abort,
  output logic [ROWS*DATA_WIDTH-1:0] out_data,
  output logic [ROWS-1:0]          out_last,
  output logic                     busy,
  output logic                     done,
  output logic [BUBBLE_CNT_W-1:0]  bubble_count
);

  skewer_state_t r_state;
  skewer_state_t w_state_nxt;
  logic          r_busy;
  logic          r_in_ready;
  logic          w_accept;
  logic          w_clr;
  logic [ROWS-1:0] w_last_nxt;

  assign w_accept = in_valid && r_in_ready && !abort;
  assign w_clr    = rst || abort;

  // Non-accepting cycles feed zero words, which also form STREAM bubbles.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    skew_delay_line #(
      .DEPTH(r + 1),
      .WIDTH(DATA_WIDTH)
    ) u_delay (
      .clk          (clk),
      .i_clr        (w_clr),
      .i_data       (w_accept ? in_data[r*DATA_WIDTH +: DATA_WIDTH] : '0),
      .i_last       (w_accept && in_last),
      .o_data       (out_data[r*DATA_WIDTH +: DATA_WIDTH]),
      .o_last       (out_last[r]),
      .o_last_nxt_c (w_last_nxt[r])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= (w_state_nxt != IDLE);
      r_in_ready <= (w_state_nxt != FLUSH);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = in_last ? FLUSH : STREAM;
      STREAM:  if (w_accept && in_last) w_state_nxt = FLUSH;
      FLUSH:   if (out_last[ROWS-1]) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (abort) w_state_nxt = IDLE;
  end

  assign busy     = r_busy;
  assign in_ready = r_in_ready;
  // Same-cycle decode of two flops: the tail row's last marker while flushing.
  assign done     = (r_state == FLUSH) && out_last[ROWS-1];

`ifdef SKEWER_BUBBLE_CNT_EN
  logic                    w_bubble;
  logic [BUBBLE_CNT_W-1:0] r_bubble_cnt;

  assign w_bubble = (r_state == STREAM) && !w_accept;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      r_bubble_cnt <= '0;
    end else if (w_accept && (r_state == IDLE)) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != {BUBBLE_CNT_W{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + BUBBLE_CNT_W'(1);
    end
  end

  assign bubble_count = r_bubble_cnt;
`else
  assign bubble_count = '0;
`endif

  // Lookahead marker is only needed by a registered-done variant of the tail row.
  logic w_unused_ok;
  assign w_unused_ok = ^w_last_nxt;

endmodule
